fpu_share_arbiter: RTL and testbench



---
 rtl/fpu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_fpu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one multi-cycle FPU core between two requesters,
// with per-requester response registers and a sticky watchdog abort.
module fpu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH = 2,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] NAN_VALUE = 'h7FC00000
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  req0ValidIn,
    output logic                  req0ReadyOut,
    input  logic [OP_WIDTH-1:0]   req0OpIn,
    input  logic [DATA_WIDTH-1:0] req0AIn,
    input  logic [DATA_WIDTH-1:0] req0BIn,
    output logic                  rsp0ValidOut,
    input  logic                  rsp0ReadyIn,
    output logic [DATA_WIDTH-1:0] rsp0DataOut,
    input  logic                  req1ValidIn,
    output logic                  req1ReadyOut,
    input  logic [OP_WIDTH-1:0]   req1OpIn,
    input  logic [DATA_WIDTH-1:0] req1AIn,
    input  logic [DATA_WIDTH-1:0] req1BIn,
    output logic                  rsp1ValidOut,
    input  logic                  rsp1ReadyIn,
    output logic [DATA_WIDTH-1:0] rsp1DataOut,
    output logic                  fpuStartOut,
    output logic [OP_WIDTH-1:0]   fpuOpOut,
    output logic [DATA_WIDTH-1:0] fpuAOut,
    output logic [DATA_WIDTH-1:0] fpuBOut,
    input  logic                  fpuDoneIn,
    input  logic [DATA_WIDTH-1:0] fpuDataIn,
    output logic                  errOut
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [OP_WIDTH-1:0] OP_RSVD = OP_WIDTH'(3);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, last_q, last_d, err_q, err_d, grant1, idle, load;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, rsp0_q, rsp0_d, rsp1_q, rsp1_d, load_val;
    logic [CW-1:0] cnt_q, cnt_d;
    // Ready is gated by reset so nothing can look accepted while the block is held in reset.
    assign idle = (state_q == IDLE) && !rstIn;
    assign grant1 = req1ValidIn && (!req0ValidIn || !last_q);
    assign req0ReadyOut = idle && req0ValidIn && !grant1;
    assign req1ReadyOut = idle && grant1;
    assign rsp0ValidOut = (state_q == RESP) && !owner_q;
    assign rsp1ValidOut = (state_q == RESP) && owner_q;
    assign rsp0DataOut = rsp0_q;
    assign rsp1DataOut = rsp1_q;
    assign fpuStartOut = state_q == ISSUE;
    assign fpuOpOut = op_q;
    assign fpuAOut = a_q;
    assign fpuBOut = b_q;
    assign errOut = err_q;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        err_d = err_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        cnt_d = cnt_q;
        rsp0_d = rsp0_q;
        rsp1_d = rsp1_q;
        load = 1'b0;
        load_val = NAN_VALUE;
        case (state_q)
            IDLE: if (req0ReadyOut || req1ReadyOut) begin
                owner_d = req1ReadyOut;
                op_d = req1ReadyOut ? req1OpIn : req0OpIn;
                a_d = req1ReadyOut ? req1AIn : req0AIn;
                b_d = req1ReadyOut ? req1BIn : req0BIn;
                load = op_d == OP_RSVD;
                state_d = (op_d == OP_RSVD) ? RESP : ISSUE;
            end
            ISSUE: begin
                cnt_d = '0;
                state_d = WAIT;
            end
            WAIT: if (fpuDoneIn) begin
                load = 1'b1;
                load_val = fpuDataIn;
                state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                load = 1'b1;
                err_d = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            RESP: if (owner_q ? rsp1ReadyIn : rsp0ReadyIn) begin
                last_d = owner_q;
                state_d = IDLE;
            end
        endcase
        // Only the owner's result register moves; the other requester keeps its last result.
        if (load) begin
            if (owner_d) rsp1_d = load_val;
            else rsp0_d = load_val;
        end
    end
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q <= 1'b1;
            err_q <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            cnt_q <= '0;
            rsp0_q <= '0;
            rsp1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            err_q <= err_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            cnt_q <= cnt_d;
            rsp0_q <= rsp0_d;
            rsp1_q <= rsp1_d;
        end
    end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed and random traffic from two requesters against a
// transaction-level model of arbitration, latency, watchdog and response ownership.
module tb_fpu_share_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] NAN = 32'h7FC00000;
    localparam logic [31:0] HANG_B = 32'hDEADBEEF;
    typedef struct packed {logic [1:0] op; logic [31:0] a; logic [31:0] b;} req_t;
    logic clkIn = 1'b0, rstIn = 1'b0;
    logic [1:0] vld, rsp_r, rdy, rsp_v, took;
    logic [1:0][1:0] opv;
    logic [1:0][31:0] av, bv, rsp_d;
    logic rdy0, rdy1, rv0, rv1, fpuStartOut, fpuDoneIn, errOut;
    logic core_done = 1'b0, spur = 1'b0;
    logic [31:0] rd0, rd1, fpuAOut, fpuBOut, fpuDataIn;
    logic [1:0] fpuOpOut;
    int errors = 0, checks = 0;
    assign rdy = {rdy1, rdy0};
    assign rsp_v = {rv1, rv0};
    assign rsp_d = {rd1, rd0};
    assign fpuDoneIn = core_done | spur;
    always #5 clkIn = ~clkIn;

    fpu_share_arbiter #(.TIMEOUT(TO)) dut (
        .clkIn(clkIn), .rstIn(rstIn),
        .req0ValidIn(vld[0]), .req0ReadyOut(rdy0), .req0OpIn(opv[0]), .req0AIn(av[0]), .req0BIn(bv[0]),
        .rsp0ValidOut(rv0), .rsp0ReadyIn(rsp_r[0]), .rsp0DataOut(rd0),
        .req1ValidIn(vld[1]), .req1ReadyOut(rdy1), .req1OpIn(opv[1]), .req1AIn(av[1]), .req1BIn(bv[1]),
        .rsp1ValidOut(rv1), .rsp1ReadyIn(rsp_r[1]), .rsp1DataOut(rd1),
        .fpuStartOut(fpuStartOut), .fpuOpOut(fpuOpOut), .fpuAOut(fpuAOut), .fpuBOut(fpuBOut),
        .fpuDoneIn(fpuDoneIn), .fpuDataIn(fpuDataIn), .errOut(errOut)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in core: known float cases answer exactly, anything else gets a distinctive hash.
    function automatic logic [31:0] core_fn(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'd1 && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
        return (a * 3) ^ b ^ {30'd0, op};
    endfunction
    function automatic int core_lat(logic [31:0] a);
        return (a[1:0] == 2'd0) ? 3 : int'(a[1:0]);
    endfunction

    int ccnt = 0;
    logic [1:0] cop;
    logic [31:0] ca, cb;
    always @(posedge clkIn) begin
        #1;
        core_done = 1'b0;
        if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) begin
                core_done = 1'b1;
                fpuDataIn = core_fn(cop, ca, cb);
            end
        end
        if (fpuStartOut && fpuBOut != HANG_B) begin
            ccnt = core_lat(fpuAOut);
            cop = fpuOpOut;
            ca = fpuAOut;
            cb = fpuBOut;
        end
    end

    logic m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1, m_err = 1'b0, m_to = 1'b0, rst_seen = 1'b0;
    logic [1:0] m_op;
    logic [31:0] m_a, m_b, m_exp;
    logic [1:0][31:0] m_data = '0;
    int n = 0, m_acc = 0, m_resp = 0, n_start = 0, n_rdy1 = 0, n_rspv = 0;
    int grants[$];
    always @(posedge rstIn) rst_seen = 1'b1;
    always @(negedge clkIn) begin : mon
        logic g1;
        logic [1:0] e_rdy;
        n++;
        if (rstIn || rst_seen) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_err = 1'b0;
            m_data = '0;
            rst_seen = 1'b0;
        end
        if (rstIn) begin
            chk("rst_ctl", {rdy, rsp_v, fpuStartOut, fpuOpOut, errOut}, 0);
            chk("rst_data", {fpuAOut | fpuBOut, rsp_d[0] | rsp_d[1]}, 0);
        end else begin
            if (m_busy && n == m_resp) begin
                m_data[m_own] = m_exp;
                if (m_to) m_err = 1'b1;
            end
            g1 = vld[1] && (!vld[0] || !m_last);
            e_rdy = m_busy ? 2'b00 : {g1, vld[0] && !g1};
            chk("ready", rdy, e_rdy);
            chk("start", fpuStartOut, m_busy && m_op != 2'd3 && n == m_acc + 1);
            chk("rsp_valid", rsp_v, (m_busy && n >= m_resp) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
            chk("rsp_data", rsp_d, m_data);
            chk("err", errOut, m_err);
            if (m_busy && m_op != 2'd3 && n > m_acc && n < m_resp)
                chk("fpu_opnd", {fpuOpOut, fpuAOut, fpuBOut}, {m_op, m_a, m_b});
            if (fpuStartOut) n_start++;
            if (rdy[1]) n_rdy1++;
            if (|rsp_v) n_rspv++;
            if (m_busy && n >= m_resp && rsp_r[m_own]) begin
                m_busy = 1'b0;
                m_last = m_own;
            end else if (!m_busy && |e_rdy) begin
                m_busy = 1'b1;
                m_own = e_rdy[1];
                m_op = opv[m_own];
                m_a = av[m_own];
                m_b = bv[m_own];
                m_acc = n;
                m_to = m_op != 2'd3 && m_b == HANG_B;
                m_resp = n + ((m_op == 2'd3) ? 1 : m_to ? 2 + TO : 2 + core_lat(m_a));
                m_exp = (m_op == 2'd3 || m_to) ? NAN : core_fn(m_op, m_a, m_b);
                grants.push_back(int'(m_own));
            end
        end
    end

    req_t q0[$], q1[$];
    int vprob = 100, rprob = 100, hold0 = 0;
    task automatic run(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge clkIn);
            #1;
            if (took[0]) vld[0] = 1'b0;
            if (took[1]) vld[1] = 1'b0;
            took = 2'b00;
            if (!vld[0] && q0.size() > 0 && int'($urandom_range(99)) < vprob) begin
                vld[0] = 1'b1;
                {opv[0], av[0], bv[0]} = q0[0];
            end
            if (!vld[1] && q1.size() > 0 && int'($urandom_range(99)) < vprob) begin
                vld[1] = 1'b1;
                {opv[1], av[1], bv[1]} = q1[0];
            end
            if (hold0 > 0 && rsp_v[0]) begin
                rsp_r[0] = 1'b0;
                hold0--;
            end else rsp_r[0] = int'($urandom_range(99)) < rprob;
            rsp_r[1] = int'($urandom_range(99)) < rprob;
            @(negedge clkIn);
            if (vld[0] && rdy[0]) begin void'(q0.pop_front()); took[0] = 1'b1; end
            if (vld[1] && rdy[1]) begin void'(q1.pop_front()); took[1] = 1'b1; end
            #1;
        end
    endtask

    task automatic rst_pulse();
        rstIn = 1'b1;
        #1;
        chk("rst_ctl_now", {rdy, rsp_v, fpuStartOut, fpuOpOut, errOut}, 0);
        chk("rst_data_now", {fpuAOut | fpuBOut, rsp_d[0] | rsp_d[1]}, 0);
        @(posedge clkIn);
        #1;
        rstIn = 1'b0;
    endtask

    task automatic clear();
        n_start = 0;
        n_rdy1 = 0;
        n_rspv = 0;
        grants.delete();
    endtask

    function automatic int gpack();
        int r = 0;
        foreach (grants[i]) r = r * 2 + grants[i];
        return (grants.size() << 8) | r;
    endfunction

    initial begin
        vld = '0; took = '0; rsp_r = '0; opv = '0; av = '0; bv = '0; fpuDataIn = '0;
        #1;
        rst_pulse();
        clear();
        q0.push_back(req_t'({2'd0, 32'h3F800000, 32'h40000000}));
        run(12);
        chk("s1_starts", n_start, 1);
        chk("s1_rsp0", rsp_d[0], 32'h40400000);
        chk("s1_req1_untouched", {n_rdy1, rsp_d[1]}, 0);
        chk("s1_grants", gpack(), (1 << 8) | 0);
        rst_pulse();
        clear();
        repeat (2) q0.push_back(req_t'({2'd2, 32'h40000000, 32'h40400000}));
        repeat (2) q1.push_back(req_t'({2'd1, 32'h40A00000, 32'h3F800000}));
        run(40);
        chk("s2_grants", gpack(), (4 << 8) | 5);
        chk("s2_rsp", rsp_d, {32'h40800000, 32'h40C00000});
        clear();
        q1.push_back(req_t'({2'd3, 32'h12345678, 32'h9ABCDEF0}));
        run(6);
        chk("s3_no_start", n_start, 0);
        chk("s3_rsp1", rsp_d[1], NAN);
        chk("s3_err", errOut, 0);
        chk("s3_grants", gpack(), (1 << 8) | 1);
        clear();
        q0.push_back(req_t'({2'd0, 32'h00001234, HANG_B}));
        q0.push_back(req_t'({2'd0, 32'h3F800000, 32'h40000000}));
        run(30);
        chk("s4_err_sticky", errOut, 1);
        chk("s4_rsp0", rsp_d[0], 32'h40400000);
        chk("s4_starts", n_start, 2);
        rst_pulse();
        clear();
        q0.push_back(req_t'({2'd0, 32'h3F800000, 32'h40000000}));
        q1.push_back(req_t'({2'd2, 32'h40000000, 32'h40400000}));
        hold0 = 10;
        run(40);
        chk("s5_hold_used", hold0, 0);
        chk("s5_grants", gpack(), (2 << 8) | 1);
        chk("s5_rsp", rsp_d, {32'h40C00000, 32'h40400000});
        rst_pulse();
        clear();
        q0.push_back(req_t'({2'd0, 32'h3F800000, 32'h40000000}));
        for (int i = 0; i < 10 && !m_busy; i++) run(1);
        chk("s6_accepted", m_busy, 1);
        run(2);
        #1;
        rst_pulse();
        run(6);
        chk("s6_no_rsp", n_rspv, 0);
        clear();
        @(posedge clkIn);
        #1 spur = 1'b1;
        @(posedge clkIn);
        #1 spur = 1'b0;
        run(4);
        chk("s6_spur_no_rsp", n_rspv, 0);
        q1.push_back(req_t'({2'd1, 32'h40A00000, 32'h3F800000}));
        run(12);
        chk("s6_back_to_idle", {rsp_d[1], rsp_d[0]}, {32'h40800000, 32'h0});
        rst_pulse();
        clear();
        vprob = 60;
        rprob = 70;
        for (int i = 0; i < 20; i++) begin
            q0.push_back(req_t'({2'($urandom_range(3)), 32'($urandom), ($urandom_range(15) == 0) ? HANG_B : 32'($urandom)}));
            q1.push_back(req_t'({2'($urandom_range(3)), 32'($urandom), ($urandom_range(15) == 0) ? HANG_B : 32'($urandom)}));
        end
        for (int i = 0; i < 3000 && !(q0.size() == 0 && q1.size() == 0 && vld == 2'b00 && !m_busy); i++) run(1);
        chk("rand_drain", {q0.size() == 0, q1.size() == 0, m_busy}, 3'b110);
        chk("rand_count", grants.size(), 40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
